cipher_stream_core: RTL and testbench
=====================================

CIPHER_STREAM_CORE -- requirements
Module: cipher_stream_core

Interface
REQ-001 Parameter DATA_W, default 8, width of the plaintext, keystream and ciphertext words.
REQ-002 Parameter DEPTH, default 16, output FIFO depth in words; power of two, at least 2.
REQ-003 Parameter CNT_W, default 16, width of the word counter and the stall counter.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_data  in  DATA_W  input word (plaintext or ciphertext).
REQ-007 in_valid  in  1 / in_ready  out  1  input handshake; a transfer occurs when both are high on a clock edge.
REQ-008 ks_data  in  DATA_W / ks_valid  in  1  keystream word from the keystream generator.
REQ-009 ks_ready  out  1  keystream consume strobe, combinational, one per XORed word.
REQ-010 out_data  out  DATA_W / out_valid  out  1 / out_ready  in  1  output handshake, first-word-fall-through.
REQ-011 mode_req  in  1  requested mode: 0 = cipher (XOR), 1 = bypass.
REQ-012 mode_act  out  1  mode currently applied to accepted words.
REQ-013 flush  in  1  synchronous single-cycle request to discard FIFO contents.
REQ-014 level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 word_count  out  CNT_W  number of accepted input words.
REQ-016 stall_count  out  CNT_W  number of keystream-starved cycles.

Function
REQ-017 The state machine SHALL have three states: RUN, DRAIN and FLUSH; its reset state is RUN.
REQ-018 In RUN, in_ready SHALL equal !full && (mode_act || ks_valid) && (mode_req == mode_act) && !flush.
REQ-019 On an input transfer the FIFO SHALL write in_data ^ ks_data when mode_act = 0, or in_data unchanged when mode_act = 1.
REQ-020 ks_ready SHALL equal in_valid && in_ready && !mode_act, so exactly one keystream word is consumed per XORed word and none are consumed in bypass.
REQ-021 A word accepted at edge N SHALL be presented on out_data with out_valid = 1 after edge N; minimum latency is one cycle.
REQ-022 out_valid SHALL equal !empty; a FIFO pop occurs on out_valid && out_ready.
REQ-023 A push and a pop in the same cycle SHALL leave level unchanged and preserve word order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; level SHALL reach DEPTH exactly when the FIFO is full.
REQ-025 When mode_req != mode_act in RUN, the FSM SHALL enter DRAIN.
REQ-026 In DRAIN, in_ready SHALL be 0 and pops SHALL continue.
REQ-027 When the FIFO becomes empty in DRAIN, mode_act SHALL load mode_req and the FSM SHALL return to RUN on the next edge.
REQ-028 flush = 1 in any state SHALL force in_ready = 0 that cycle and move the FSM to FLUSH; flush has priority over DRAIN.
REQ-029 In FLUSH, for exactly one cycle, the FIFO pointers and level SHALL clear, word_count SHALL clear, out_valid SHALL be 0 and in_ready SHALL be 0; the FSM SHALL then enter RUN, or DRAIN if mode_req != mode_act.
REQ-030 A pop requested in the cycle flush is asserted SHALL be ignored.
REQ-031 word_count SHALL increment by 1 per input transfer and wrap from 2^CNT_W-1 to 0.
REQ-032 stall_count SHALL increment in each RUN cycle with in_valid = 1, mode_act = 0, FIFO not full and ks_valid = 0; it saturates at 2^CNT_W-1 and clears only on reset.
REQ-033 No input transfer or keystream consumption SHALL occur while the FIFO is full, regardless of out_ready in that cycle.

Reset
REQ-034 On rst_n = 0, asynchronously: FSM = RUN, FIFO empty, level = 0, out_valid = 0, in_ready = 0, ks_ready = 0, mode_act = 0, word_count = 0, stall_count = 0.
REQ-035 FIFO storage contents need not be reset; out_data is don't-care while out_valid = 0.
REQ-036 Reset asserted mid-transfer SHALL discard all buffered words; after release, the first accepted word SHALL be the first word written.

Verification
REQ-037 Cipher mode: in 0x41, 0x42, 0x43 with ks 0xFF, 0x0F, 0xAA, out_ready = 1 -> out 0xBE, 0x4D, 0xE9, each one cycle after its accept; three ks_ready pulses; word_count = 3.
REQ-038 Full boundary (DEPTH = 16, out_ready = 0): 17 valid inputs -> 16 accepted, level = 16, in_ready = 0, ks_ready = 0; one pop then frees a slot and the 17th word is accepted.
REQ-039 Keystream starve: in_valid = 1, ks_valid = 0 for 5 cycles -> in_ready = 0, stall_count = 5; raise ks_valid -> accept on that edge.
REQ-040 Mode switch with 4 words buffered: set mode_req = 1 -> DRAIN, in_ready = 0; after the 4 pops, mode_act = 1; then input 0x55 -> out 0x55 with no ks_ready pulse.
REQ-041 Flush with level = 7 and out_ready = 1 -> next cycle level = 0, out_valid = 0, word_count = 0, no word popped; stall_count retained.
REQ-042 Async reset pulse mid-stream with level = 5 -> all outputs at reset values immediately; after release, input 0x10 with ks 0x01 -> out 0x11.

Source files
------------

// File: rtl/cipher_stream_if.sv
// cipher_stream_if: plaintext, keystream and output handshakes of the cipher stream core.
interface cipher_stream_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] ks_data;
    logic              ks_valid;
    logic              ks_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    modport master (
        output in_data, in_valid, ks_data, ks_valid, out_ready,
        input  in_ready, ks_ready, out_data, out_valid
    );
    modport slave (
        input  in_data, in_valid, ks_data, ks_valid, out_ready,
        output in_ready, ks_ready, out_data, out_valid
    );
endinterface

// File: rtl/cipher_stream_core.sv
// cipher_stream_core: XOR/bypass stream cipher stage feeding a first-word-fall-through FIFO,
// with drain-before-mode-switch and single-cycle flush.
module cipher_stream_core #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cipher_stream_if.slave           bus,
    input  logic                     mode_req,
    input  logic                     flush,
    output logic                     mode_act,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         word_count,
    output logic [CNT_W-1:0]         stall_count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;
    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              full, empty, push, pop, stall, in_rdy;
    assign full  = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        if (flush)
            state_nxt = FLUSH;
        else if (state == DRAIN)
            state_nxt = empty ? RUN : DRAIN;
        else
            state_nxt = (mode_req != mode_act) ? DRAIN : RUN;
        // rst_n gates the combinational ready so it reads 0 throughout reset
        in_rdy = rst_n && state == RUN && !full && (mode_act || bus.ks_valid) &&
                 mode_req == mode_act && !flush;
    end
    assign bus.in_ready  = in_rdy;
    assign push          = bus.in_valid && in_rdy;
    assign bus.ks_ready  = push && !mode_act;
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem[rd_ptr];
    assign pop           = !empty && bus.out_ready && !flush;
    assign stall         = state == RUN && bus.in_valid && !mode_act && !full && !bus.ks_valid;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.in_data ^ ({DATA_W{!mode_act}} & bus.ks_data);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            mode_act    <= 1'b0;
            word_count  <= '0;
            stall_count <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level      <= '0;
                word_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                level <= level + (AW+1)'(push) - (AW+1)'(pop);
                if (push) word_count <= word_count + CNT_W'(1);
            end
            if (state == DRAIN && empty && !flush) mode_act <= mode_req;
            if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_cipher_stream_core.sv
// tb_cipher_stream_core: scoreboard bench for cipher_stream_core; expected words are
// queued on acceptance and compared as the FIFO pops them.
module tb_cipher_stream_core;
    localparam int DW = 8, DEPTH = 16, CW = 16;
    logic          clk = 1'b0, rst_n = 1'b0, mode_req = 1'b0, flush = 1'b0;
    logic          mode_act;
    logic [4:0]    level;
    logic [CW-1:0] word_count, stall_count;
    int            total = 0, passed = 0, ks_pulses = 0;
    logic          mode_m = 1'b0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_w;

    cipher_stream_if #(.DATA_W(DW)) bus();

    cipher_stream_core #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .mode_req(mode_req), .flush(flush),
        .mode_act(mode_act), .level(level), .word_count(word_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // scoreboard: sampled mid-cycle, the pending edge will perform exactly these transfers
    always @(negedge clk) begin
        if (!rst_n) q.delete();
        else begin
            if (bus.out_valid && bus.out_ready && !flush) begin
                total++;
                if (q.size() == 0) $display("FAIL sb_underflow: popped %h, expected nothing", bus.out_data);
                else begin
                    exp_w = q.pop_front();
                    if (bus.out_data !== exp_w) $display("FAIL sb_data: got %h want %h", bus.out_data, exp_w);
                    else passed++;
                end
            end
            if (flush) q.delete();
            else if (bus.in_valid && bus.in_ready) q.push_back(mode_m ? bus.in_data : bus.in_data ^ bus.ks_data);
            if (bus.ks_ready) ks_pulses++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b1; bus.ks_valid = 1'b1; bus.out_ready = 1'b1;
        bus.in_data = 8'h00; bus.ks_data = 8'h00;
        #3;
        total++; if (level !== 5'd0) $display("FAIL rst_level: got %0d want 0", level); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); else passed++;
        total++; if (bus.ks_ready !== 1'b0) $display("FAIL rst_ks_ready: got %b want 0", bus.ks_ready); else passed++;
        total++; if (mode_act !== 1'b0 || word_count !== '0 || stall_count !== '0)
            $display("FAIL rst_regs: mode %b wc %0d sc %0d want 0 0 0", mode_act, word_count, stall_count); else passed++;
        tick;
        bus.in_valid = 1'b0; bus.ks_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_cipher;
        logic [DW-1:0] pt[3] = '{8'h41, 8'h42, 8'h43};
        logic [DW-1:0] ks[3] = '{8'hFF, 8'h0F, 8'hAA};
        logic [DW-1:0] ct[3] = '{8'hBE, 8'h4D, 8'hE9};
        ks_pulses = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            bus.in_data = pt[i]; bus.ks_data = ks[i]; bus.in_valid = 1'b1; bus.ks_valid = 1'b1;
            #1;
            total++; if (bus.in_ready !== 1'b1 || bus.ks_ready !== 1'b1)
                $display("FAIL cipher_ready%0d: in_ready %b ks_ready %b want 1 1", i, bus.in_ready, bus.ks_ready); else passed++;
            tick;
            bus.in_valid = 1'b0; bus.ks_valid = 1'b0;
            #1;
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== ct[i])
                $display("FAIL cipher_out%0d: valid %b data %h want 1 %h", i, bus.out_valid, bus.out_data, ct[i]); else passed++;
        end
        tick;
        total++; if (word_count !== 16'd3) $display("FAIL cipher_wc: got %0d want 3", word_count); else passed++;
        total++; if (ks_pulses !== 3) $display("FAIL cipher_ks_pulses: got %0d want 3", ks_pulses); else passed++;
    endtask

    task automatic test_full;
        int acc = 0, n = 0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.ks_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.in_data = DW'($urandom); bus.ks_data = DW'($urandom);
            #1;
            if (bus.in_ready) acc++;
            tick;
        end
        total++; if (acc !== 16) $display("FAIL full_accepts: got %0d want 16", acc); else passed++;
        total++; if (level !== 5'd16) $display("FAIL full_level: got %0d want 16", level); else passed++;
        total++; if (bus.in_ready !== 1'b0 || bus.ks_ready !== 1'b0)
            $display("FAIL full_ready: in %b ks %b want 0 0", bus.in_ready, bus.ks_ready); else passed++;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL full_pop_ready: got %b want 0", bus.in_ready); else passed++;
        tick;
        bus.out_ready = 1'b0;
        #1;
        total++; if (level !== 5'd15 || bus.in_ready !== 1'b1)
            $display("FAIL full_slot: level %0d in_ready %b want 15 1", level, bus.in_ready); else passed++;
        tick;
        bus.in_valid = 1'b0; bus.ks_valid = 1'b0;
        total++; if (level !== 5'd16) $display("FAIL full_refill: got %0d want 16", level); else passed++;
        bus.out_ready = 1'b1;
        while (level != 0 && n < 40) begin tick; n++; end
        total++; if (n >= 40) $display("FAIL full_drain_timeout: level %0d want 0", level); else passed++;
        total++; if (word_count !== 16'd20) $display("FAIL full_wc: got %0d want 20", word_count); else passed++;
    endtask

    task automatic test_starve;
        int bad = 0;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.ks_valid = 1'b0;
        bus.in_data = 8'h3C; bus.ks_data = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.in_ready !== 1'b0) bad++;
            tick;
        end
        total++; if (bad !== 0) $display("FAIL starve_ready: in_ready high %0d cycles want 0", bad); else passed++;
        total++; if (stall_count !== 16'd5) $display("FAIL starve_count: got %0d want 5", stall_count); else passed++;
        bus.ks_valid = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL starve_resume: got %b want 1", bus.in_ready); else passed++;
        tick;
        bus.in_valid = 1'b0; bus.ks_valid = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF)
            $display("FAIL starve_out: valid %b data %h want 1 ff", bus.out_valid, bus.out_data); else passed++;
        total++; if (word_count !== 16'd21) $display("FAIL starve_wc: got %0d want 21", word_count); else passed++;
        tick;
    endtask

    task automatic test_mode_switch;
        int n = 0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.ks_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = DW'($urandom); bus.ks_data = DW'($urandom);
            tick;
        end
        bus.in_valid = 1'b0;
        mode_req = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0 || level !== 5'd4)
            $display("FAIL sw_request: in_ready %b level %0d want 0 4", bus.in_ready, level); else passed++;
        tick;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0 || mode_act !== 1'b0)
            $display("FAIL sw_drain: in_ready %b mode_act %b want 0 0", bus.in_ready, mode_act); else passed++;
        while (mode_act != 1'b1 && n < 20) begin tick; n++; end
        total++; if (n >= 20 || level !== 5'd0)
            $display("FAIL sw_done: mode_act %b level %0d want 1 0", mode_act, level); else passed++;
        mode_m = 1'b1;
        ks_pulses = 0;
        bus.in_data = 8'h55; bus.ks_data = 8'hA5; bus.in_valid = 1'b1; bus.ks_valid = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1 || bus.ks_ready !== 1'b0)
            $display("FAIL sw_bypass_ready: in %b ks %b want 1 0", bus.in_ready, bus.ks_ready); else passed++;
        tick;
        bus.in_valid = 1'b0; bus.ks_valid = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h55)
            $display("FAIL sw_bypass_out: valid %b data %h want 1 55", bus.out_valid, bus.out_data); else passed++;
        tick;
        total++; if (ks_pulses !== 0) $display("FAIL sw_ks_pulses: got %0d want 0", ks_pulses); else passed++;
        mode_req = 1'b0;
        n = 0;
        while (mode_act != 1'b0 && n < 20) begin tick; n++; end
        total++; if (n >= 20) $display("FAIL sw_back_timeout: mode_act %b want 0", mode_act); else passed++;
        mode_m = 1'b0;
    endtask

    task automatic test_flush;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.ks_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_data = DW'($urandom); bus.ks_data = DW'($urandom);
            tick;
        end
        total++; if (level !== 5'd7 || word_count !== 16'd33)
            $display("FAIL flush_pre: level %0d wc %0d want 7 33", level, word_count); else passed++;
        flush = 1'b1; bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", bus.in_ready); else passed++;
        tick;
        flush = 1'b0;
        total++; if (level !== 5'd0 || bus.out_valid !== 1'b0 || word_count !== '0)
            $display("FAIL flush_clear: level %0d valid %b wc %0d want 0 0 0", level, bus.out_valid, word_count); else passed++;
        total++; if (stall_count !== 16'd5) $display("FAIL flush_stall: got %0d want 5", stall_count); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_state_ready: got %b want 0", bus.in_ready); else passed++;
        tick;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_resume: got %b want 1", bus.in_ready); else passed++;
        tick;
        bus.in_valid = 1'b0; bus.ks_valid = 1'b0;
        total++; if (word_count !== 16'd1) $display("FAIL flush_wc: got %0d want 1", word_count); else passed++;
        tick;
    endtask

    task automatic test_back_to_back;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.ks_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = DW'($urandom); bus.ks_data = DW'($urandom);
            tick;
        end
        total++; if (level !== 5'd1) $display("FAIL b2b_level: got %0d want 1", level); else passed++;
        bus.in_valid = 1'b0; bus.ks_valid = 1'b0;
        tick;
        total++; if (level !== 5'd0 || word_count !== 16'd9)
            $display("FAIL b2b_end: level %0d wc %0d want 0 9", level, word_count); else passed++;
    endtask

    task automatic test_async_reset;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.ks_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = DW'($urandom); bus.ks_data = DW'($urandom);
            tick;
        end
        total++; if (level !== 5'd5) $display("FAIL arst_pre: got %0d want 5", level); else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if (level !== 5'd0 || bus.out_valid !== 1'b0)
            $display("FAIL arst_fifo: level %0d valid %b want 0 0", level, bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b0 || bus.ks_ready !== 1'b0)
            $display("FAIL arst_ready: in %b ks %b want 0 0", bus.in_ready, bus.ks_ready); else passed++;
        total++; if (mode_act !== 1'b0 || word_count !== '0 || stall_count !== '0)
            $display("FAIL arst_regs: mode %b wc %0d sc %0d want 0 0 0", mode_act, word_count, stall_count); else passed++;
        tick;
        rst_n = 1'b1;
        bus.in_data = 8'h10; bus.ks_data = 8'h01;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL arst_resume: got %b want 1", bus.in_ready); else passed++;
        tick;
        bus.in_valid = 1'b0; bus.ks_valid = 1'b0; bus.out_ready = 1'b1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11)
            $display("FAIL arst_out: valid %b data %h want 1 11", bus.out_valid, bus.out_data); else passed++;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_cipher;
        test_full;
        test_starve;
        test_mode_switch;
        test_flush;
        test_back_to_back;
        test_async_reset;
        tick;
        total++; if (q.size() != 0) $display("FAIL sb_leftover: %0d words pending want 0", q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
